// File: rtl/bit_reversal.sv
// Registered bit-order permutation stage: full reverse, nibble reverse,
// byte swap or pass-through, behind a single-entry valid/ready register.
module bit_reversal #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out
);

  localparam int NB = WIDTH / 8;
  localparam int NN = WIDTH / 4;

  logic [WIDTH-1:0] rev_full;
  logic [WIDTH-1:0] rev_nib;
  logic [WIDTH-1:0] swap;
  logic [WIDTH-1:0] perm;
  logic             accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_full
    assign rev_full[i] = data_in[WIDTH-1-i];
  end

  for (genvar k = 0; k < NN; k++) begin : g_nib
    for (genvar j = 0; j < 4; j++) begin : g_bit
      assign rev_nib[4*k+j] = data_in[4*k+3-j];
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_swap
    assign swap[8*b +: 8] = data_in[8*(NB-1-b) +: 8];
  end

  always_comb begin
    perm = data_in;
    unique case (mode)
      2'd0: perm = rev_full;
      2'd1: perm = rev_nib;
      2'd2: perm = swap;
      2'd3: perm = data_in;
    endcase
  end

  // A held word blocks new input until downstream takes it.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      data_out  <= perm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_reversal.sv
// Directed and scoreboard checks for bit_reversal at WIDTH=8 and WIDTH=16.
module tb_bit_reversal;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv8, ir8, ov8, or8;
  logic [7:0]  di8, do8;
  logic [1:0]  md8;
  logic        iv16, ir16, ov16, or16;
  logic [15:0] di16, do16;
  logic [1:0]  md16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bit_reversal #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .data_in(di8), .mode(md8),
    .out_valid(ov8), .out_ready(or8),
    .data_out(do8)
  );

  bit_reversal #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16),
    .data_in(di16), .mode(md16),
    .out_valid(ov16), .out_ready(or16),
    .data_out(do16)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref8(input logic [7:0] d,
                                      input logic [1:0] m);
    logic [7:0] r;
    r = d;
    if (m == 2'd0) for (int i = 0; i < 8; i++) r[i] = d[7-i];
    if (m == 2'd1) r = {d[4], d[5], d[6], d[7], d[0], d[1], d[2], d[3]};
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] d,
                        input logic [1:0] m, input logic r);
    iv8 = v;
    di8 = d;
    md8 = m;
    or8 = r;
  endtask

  logic [7:0] fr_in  [4] = '{8'b10110011, 8'b11111111,
                             8'b00000001, 8'b10000000};
  logic [7:0] fr_exp [4] = '{8'b11001101, 8'b11111111,
                             8'b10000000, 8'b00000001};
  logic [1:0]  m16  [3] = '{2'd2, 2'd0, 2'd1};
  logic [15:0] e16  [3] = '{16'hF012, 16'h0F48, 16'h84F0};

  logic [7:0] q[$];
  logic [7:0] exp_w;
  logic [31:0] rnd;
  logic       acc, drn, eir;

  initial begin
    rst = 1'b1;
    drive8(1'b0, 8'h00, 2'd0, 1'b1);
    iv16 = 1'b0; di16 = '0; md16 = 2'd0; or16 = 1'b1;
    #1;
    chk("rst_in_ready", {15'd0, ir8}, 16'd0);
    step();
    chk("rst_out_valid", {15'd0, ov8}, 16'd0);
    chk("rst_data_out", {8'd0, do8}, 16'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {15'd0, ir8}, 16'd1);

    for (int i = 0; i < 4; i++) begin
      drive8(1'b1, fr_in[i], 2'd0, 1'b1);
      step();
      chk("full_data", {8'd0, do8}, {8'd0, fr_exp[i]});
      chk("full_valid", {15'd0, ov8}, 16'd1);
    end
    drive8(1'b0, 8'h00, 2'd0, 1'b1);
    step();
    chk("drain_valid", {15'd0, ov8}, 16'd0);
    chk("drain_hold", {8'd0, do8}, 16'h0001);

    drive8(1'b1, 8'b10110011, 2'd1, 1'b1);
    step();
    chk("nib_m1", {8'd0, do8}, {8'd0, 8'b11011100});
    drive8(1'b1, 8'b10110011, 2'd2, 1'b1);
    step();
    chk("nib_m2", {8'd0, do8}, {8'd0, 8'b10110011});
    drive8(1'b1, 8'b10110011, 2'd3, 1'b1);
    step();
    chk("nib_m3", {8'd0, do8}, {8'd0, 8'b10110011});
    drive8(1'b0, 8'h00, 2'd0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      iv16 = 1'b1; di16 = 16'h12F0; md16 = m16[i];
      step();
      chk("w16_data", do16, e16[i]);
      chk("w16_valid", {15'd0, ov16}, 16'd1);
    end
    iv16 = 1'b0;
    step();

    drive8(1'b1, 8'h01, 2'd0, 1'b1);
    step();
    chk("bp_first", {8'd0, do8}, 16'h0080);
    drive8(1'b1, 8'h02, 2'd0, 1'b0);
    #1;
    chk("bp_in_ready", {15'd0, ir8}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data", {8'd0, do8}, 16'h0080);
      chk("bp_hold_valid", {15'd0, ov8}, 16'd1);
      chk("bp_hold_ready", {15'd0, ir8}, 16'd0);
    end
    or8 = 1'b1;
    #1;
    chk("bp_release_ready", {15'd0, ir8}, 16'd1);
    step();
    chk("bp_second", {8'd0, do8}, 16'h0040);
    chk("bp_second_valid", {15'd0, ov8}, 16'd1);
    drive8(1'b0, 8'h00, 2'd0, 1'b1);
    step();

    drive8(1'b1, 8'h01, 2'd0, 1'b1);
    step();
    drive8(1'b0, 8'h00, 2'd0, 1'b0);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", {15'd0, ov8}, 16'd0);
    chk("mid_rst_data", {8'd0, do8}, 16'd0);
    drive8(1'b1, 8'hAA, 2'd3, 1'b1);
    step();
    chk("rst_vs_accept_valid", {15'd0, ov8}, 16'd0);
    chk("rst_vs_accept_data", {8'd0, do8}, 16'd0);
    rst = 1'b0;
    drive8(1'b0, 8'h00, 2'd0, 1'b1);
    step();

    q.delete();
    for (int n = 0; n < 1000; n++) begin
      rnd = $urandom;
      drive8(rnd[8], rnd[7:0], rnd[10:9], rnd[11] | rnd[12]);
      #1;
      eir = (q.size() == 0) || or8;
      acc = iv8 && eir;
      drn = (q.size() != 0) && or8;
      chk("rnd_in_ready", {15'd0, ir8}, {15'd0, eir});
      chk("rnd_out_valid", {15'd0, ov8}, {15'd0, q.size() != 0});
      if (drn) begin
        exp_w = q.pop_front();
        chk("rnd_data", {8'd0, do8}, {8'd0, exp_w});
      end
      if (acc) q.push_back(ref8(di8, md8));
      step();
    end
    drive8(1'b0, 8'h00, 2'd0, 1'b1);
    #1;
    if (q.size() != 0) begin
      exp_w = q.pop_front();
      chk("rnd_tail", {8'd0, do8}, {8'd0, exp_w});
    end
    step();
    chk("rnd_empty", {15'd0, ov8}, 16'd0);
    chk("rnd_queue", q.size(), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
